// File: rtl/wb_writer.sv
// Writeback arbiter: ALU results and FIFO-buffered load results share one
// registered register-file write port. Define WB_STARVE_GUARD_EN to bound load starvation.
module wb_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_alu_valid,
    output logic                          o_alu_ready,
    input  logic [4:0]                    i_alu_rd,
    input  logic [31:0]                   i_alu_data,
    input  logic                          i_mem_valid,
    output logic                          o_mem_ready,
    input  logic [4:0]                    i_mem_rd,
    input  logic [31:0]                   i_mem_data,
    output logic [4:0]                    o_rd_addr,
    output logic [31:0]                   o_rd_data,
    output logic                          o_rd_we,
    output logic [$clog2(FIFO_DEPTH):0]   o_mem_pending
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [4:0]    r_fifo_rd   [FIFO_DEPTH];
    logic [31:0]   r_fifo_data [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic [4:0]    r_rd_addr;
    logic [31:0]   r_rd_data;
    logic          r_rd_we;

    logic          w_full, w_empty, w_enq, w_trig;
    logic          w_alu_win, w_fifo_win;
    logic [4:0]    w_win_rd;
    logic [31:0]   w_win_data;

    assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign o_mem_ready = !w_full;
    // x0 loads complete the handshake but never occupy a slot
    assign w_enq       = i_mem_valid && !w_full && (i_mem_rd != 5'd0);

`ifdef WB_STARVE_GUARD_EN
    localparam int SCW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    logic [SCW-1:0] r_starve;

    assign w_trig = !w_empty && (r_starve == SCW'(STARVE_MAX));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            r_starve <= '0;
        else if (w_fifo_win || w_empty)
            r_starve <= '0;
        else if (w_alu_win)
            r_starve <= r_starve + 1'b1;
    end
`else
    assign w_trig = 1'b0;
`endif

    assign o_alu_ready = !w_trig;
    assign w_alu_win   = !w_trig && i_alu_valid;
    assign w_fifo_win  = w_trig || (!i_alu_valid && !w_empty);
    assign w_win_rd    = w_alu_win ? i_alu_rd   : r_fifo_rd[r_rptr];
    assign w_win_data  = w_alu_win ? i_alu_data : r_fifo_data[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_fifo_rd[r_wptr]   <= i_mem_rd;
            r_fifo_data[r_wptr] <= i_mem_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_wptr <= r_wptr + 1'b1;
            if (w_fifo_win)
                r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_fifo_win})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_we   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else if ((w_alu_win || w_fifo_win) && (w_win_rd != 5'd0)) begin
            r_rd_we   <= 1'b1;
            r_rd_addr <= w_win_rd;
            r_rd_data <= w_win_data;
        end else begin
            r_rd_we   <= 1'b0;
        end
    end

    assign o_rd_we       = r_rd_we;
    assign o_rd_addr     = r_rd_addr;
    assign o_rd_data     = r_rd_data;
    assign o_mem_pending = r_count;
endmodule
